// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter sharing the register file's single write port
// between the ALU result path (A) and the memory-load path (B). The winning
// write is registered and presented to the register file one cycle later.
// Writes to register 0 are dropped and counted.
module regfile_wb_arbiter #(
    parameter int ADDR  = 5,
    parameter int SIZE  = 32,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Hold,
    input  logic             A_Valid,
    input  logic [ADDR-1:0]  A_Addr,
    input  logic [SIZE-1:0]  A_Data,
    output logic             A_Ready,
    input  logic             B_Valid,
    input  logic [ADDR-1:0]  B_Addr,
    input  logic [SIZE-1:0]  B_Data,
    output logic             B_Ready,
    output logic             Write_Reg,
    output logic [ADDR-1:0]  W_Addr,
    output logic [SIZE-1:0]  W_Data,
    output logic [CNT_W-1:0] Drop_Cnt,
    output logic [CNT_W-1:0] Conflict_Cnt
);

    // Which source wins the next conflict.
    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_t;

    rr_t             rr_q;
    rr_t             rr_d;
    logic            a_grant;
    logic            b_grant;
    logic            xfer_p0;
    logic            zero_p0;
    logic [ADDR-1:0] addr_p0;
    logic [SIZE-1:0] data_p0;
    logic            vld_p1;
    logic [ADDR-1:0] addr_p1;
    logic [SIZE-1:0] data_p1;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] conf_cnt_q;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Grant decision and pointer next-state; grants never look at Addr/Data.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        rr_d    = rr_q;
        if (!Clr && !Hold) begin
            if (A_Valid && (!B_Valid || rr_q == RR_A)) begin
                a_grant = 1'b1;
            end else if (B_Valid) begin
                b_grant = 1'b1;
            end
        end
        // Priority passes to whichever source did not just transfer.
        if (a_grant) begin
            rr_d = RR_B;
        end else if (b_grant) begin
            rr_d = RR_A;
        end
    end

    // Pointer register; after reset A is preferred.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            rr_q <= RR_A;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Stage p0: mux the granted request.
    always_comb begin
        xfer_p0 = a_grant | b_grant;
        addr_p0 = b_grant ? B_Addr : A_Addr;
        data_p0 = b_grant ? B_Data : A_Data;
        zero_p0 = (addr_p0 == '0);
    end

    // Stage p1: registered write; register-0 writes are dropped, address/data hold.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= xfer_p0 && !zero_p0;
            if (xfer_p0 && !zero_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
            end
        end
    end

    // Statistics: dropped register-0 writes and contended (non-held) cycles.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            drop_cnt_q <= '0;
            conf_cnt_q <= '0;
        end else begin
            if (xfer_p0 && zero_p0) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
            if (A_Valid && B_Valid && !Hold) begin
                conf_cnt_q <= sat_inc(conf_cnt_q);
            end
        end
    end

    assign A_Ready      = a_grant;
    assign B_Ready      = b_grant;
    assign Write_Reg    = vld_p1;
    assign W_Addr       = addr_p1;
    assign W_Data       = data_p1;
    assign Drop_Cnt     = drop_cnt_q;
    assign Conflict_Cnt = conf_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model. A second
// instance with 2-bit counters exercises saturation.
module tb_regfile_wb_arbiter;

    logic        Clk;
    logic        Clr;
    logic        Hold;
    logic        A_Valid;
    logic [4:0]  A_Addr;
    logic [31:0] A_Data;
    logic        A_Ready;
    logic        B_Valid;
    logic [4:0]  B_Addr;
    logic [31:0] B_Data;
    logic        B_Ready;
    logic        Write_Reg;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic [7:0]  Drop_Cnt;
    logic [7:0]  Conflict_Cnt;

    logic        s_A_Ready;
    logic        s_B_Ready;
    logic        s_Write_Reg;
    logic [4:0]  s_W_Addr;
    logic [31:0] s_W_Data;
    logic [1:0]  s_Drop_Cnt;
    logic [1:0]  s_Conflict_Cnt;

    regfile_wb_arbiter #(.ADDR(5), .SIZE(32), .CNT_W(8)) u_dut (
        .Clk(Clk), .Clr(Clr), .Hold(Hold),
        .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_Ready(A_Ready),
        .B_Valid(B_Valid), .B_Addr(B_Addr), .B_Data(B_Data), .B_Ready(B_Ready),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
        .Drop_Cnt(Drop_Cnt), .Conflict_Cnt(Conflict_Cnt)
    );

    regfile_wb_arbiter #(.ADDR(5), .SIZE(32), .CNT_W(2)) u_sat (
        .Clk(Clk), .Clr(Clr), .Hold(Hold),
        .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_Ready(s_A_Ready),
        .B_Valid(B_Valid), .B_Addr(B_Addr), .B_Data(B_Data), .B_Ready(s_B_Ready),
        .Write_Reg(s_Write_Reg), .W_Addr(s_W_Addr), .W_Data(s_W_Data),
        .Drop_Cnt(s_Drop_Cnt), .Conflict_Cnt(s_Conflict_Cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        clr;
        logic        hold;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ear;
        logic        ebr;
        logic        ewr;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        int          edrop;
        int          econf;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: preferred source for the next conflict, last visible write, counters.
    int          m_pref;
    int          m_wr;
    int          m_wa;
    int          m_wd;
    int          m_drop;
    int          m_conf;
    int          m_drop2;
    int          m_conf2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Decide the winner from the rules, then advance the model by one clock.
    task automatic model_step(input vec_t v, output bit ga, output bit gb);
        int addr;
        int data;
        ga = 0;
        gb = 0;
        if (!v.clr && !v.hold) begin
            if (v.av && v.bv) begin
                if (m_pref == 0) ga = 1; else gb = 1;
            end else if (v.av) begin
                ga = 1;
            end else if (v.bv) begin
                gb = 1;
            end
        end
        if (v.clr) begin
            m_pref = 0; m_wr = 0; m_wa = 0; m_wd = 0;
            m_drop = 0; m_conf = 0; m_drop2 = 0; m_conf2 = 0;
        end else begin
            if (v.av && v.bv && !v.hold) begin
                m_conf  = sat(m_conf + 1, 255);
                m_conf2 = sat(m_conf2 + 1, 3);
            end
            if (ga || gb) begin
                addr   = ga ? int'(v.aa) : int'(v.ba);
                data   = ga ? int'(v.ad) : int'(v.bd);
                m_pref = ga ? 1 : 0;
                if (addr != 0) begin
                    m_wr = 1; m_wa = addr; m_wd = data;
                end else begin
                    m_wr = 0;
                    m_drop  = sat(m_drop + 1, 255);
                    m_drop2 = sat(m_drop2 + 1, 3);
                end
            end else begin
                m_wr = 0;
            end
        end
    endtask

    // One clock cycle: drive, check Ready at negedge, check registered outputs after posedge.
    task automatic apply(input vec_t v, input bit use_tbl, output bit ga, output bit gb);
        Clr = v.clr; Hold = v.hold;
        A_Valid = v.av; A_Addr = v.aa; A_Data = v.ad;
        B_Valid = v.bv; B_Addr = v.ba; B_Data = v.bd;
        @(negedge Clk);
        model_step(v, ga, gb);
        if (use_tbl) begin
            chk("a_ready", A_Ready, v.ear);
            chk("b_ready", B_Ready, v.ebr);
        end else begin
            chk("a_ready", A_Ready, ga);
            chk("b_ready", B_Ready, gb);
        end
        @(posedge Clk);
        #1;
        if (use_tbl) begin
            chk("write_reg", Write_Reg, v.ewr);
            chk("w_addr", W_Addr, v.ewa);
            chk("w_data", W_Data, v.ewd);
            chk("drop_cnt", Drop_Cnt, v.edrop);
            chk("conflict_cnt", Conflict_Cnt, v.econf);
        end else begin
            chk("write_reg", Write_Reg, m_wr);
            chk("w_addr", W_Addr, m_wa);
            chk("w_data", W_Data, m_wd);
            chk("drop_cnt", Drop_Cnt, m_drop);
            chk("conflict_cnt", Conflict_Cnt, m_conf);
        end
        chk("sat_drop_cnt", s_Drop_Cnt, m_drop2);
        chk("sat_conflict_cnt", s_Conflict_Cnt, m_conf2);
    endtask

    vec_t tbl[10];
    vec_t v;
    bit   ga, gb;
    bit   pa, pb;
    logic [4:0]  ra_a, rb_a;
    logic [31:0] ra_d, rb_d;

    initial begin
        Clr = 1'b1; Hold = 1'b0;
        A_Valid = 1'b0; A_Addr = '0; A_Data = '0;
        B_Valid = 1'b0; B_Addr = '0; B_Data = '0;
        m_pref = 0; m_wr = 0; m_wa = 0; m_wd = 0;
        m_drop = 0; m_conf = 0; m_drop2 = 0; m_conf2 = 0;

        // clr hold av aa ad        bv ba ba_data   ear ebr ewr ewa ewd         drop conf
        tbl[0] = '{1, 0, 1, 5, 32'h1234, 0, 0,  0,          0, 0, 0, 0,  0,          0, 0};
        tbl[1] = '{0, 0, 1, 5, 32'h1234, 0, 0,  0,          1, 0, 1, 5,  32'h1234,   0, 0};
        tbl[2] = '{0, 0, 0, 0, 0,        0, 0,  0,          0, 0, 0, 5,  32'h1234,   0, 0};
        tbl[3] = '{1, 0, 0, 0, 0,        0, 0,  0,          0, 0, 0, 0,  0,          0, 0};
        tbl[4] = '{0, 0, 1, 1, 32'h11,   1, 9,  32'h99,     1, 0, 1, 1,  32'h11,     0, 1};
        tbl[5] = '{0, 0, 1, 2, 32'h22,   1, 9,  32'h99,     0, 1, 1, 9,  32'h99,     0, 2};
        tbl[6] = '{0, 0, 1, 2, 32'h22,   1, 10, 32'hA0,     1, 0, 1, 2,  32'h22,     0, 3};
        tbl[7] = '{0, 0, 1, 3, 32'h33,   1, 10, 32'hA0,     0, 1, 1, 10, 32'hA0,     0, 4};
        tbl[8] = '{0, 0, 0, 0, 0,        1, 0,  32'hFFFF,   0, 1, 0, 10, 32'hA0,     1, 4};
        tbl[9] = '{0, 0, 0, 0, 0,        0, 0,  0,          0, 0, 0, 10, 32'hA0,     1, 4};

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i], 1'b1, ga, gb);
        end

        // Hold during contention: no grants, no conflict counting; A (pointer) wins on release.
        for (int i = 0; i < 3; i++) begin
            v = '{0, 1, 1, 4, 32'h44, 1, 11, 32'hBB, 0, 0, 0, 10, 32'hA0, 1, 4};
            apply(v, 1'b1, ga, gb);
        end
        v = '{0, 0, 1, 4, 32'h44, 1, 11, 32'hBB, 1, 0, 1, 4, 32'h44, 1, 5};
        apply(v, 1'b1, ga, gb);

        // Clr right after a transfer: in-flight write cleared, pointer back to A.
        v = '{0, 0, 1, 7, 32'h77, 0, 0, 0, 1, 0, 1, 7, 32'h77, 1, 5};
        apply(v, 1'b1, ga, gb);
        v = '{1, 0, 1, 8, 32'h88, 1, 12, 32'hCC, 0, 0, 0, 0, 0, 0, 0};
        apply(v, 1'b1, ga, gb);
        v = '{0, 0, 1, 8, 32'h88, 1, 12, 32'hCC, 1, 0, 1, 8, 32'h88, 0, 1};
        apply(v, 1'b1, ga, gb);

        // Saturation: five register-0 writes; the 2-bit counter stops at 3.
        v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        apply(v, 1'b1, ga, gb);
        for (int i = 1; i <= 5; i++) begin
            v = '{0, 0, 1, 0, i, 0, 0, 0, 1, 0, 0, 0, 0, i, 0};
            apply(v, 1'b1, ga, gb);
        end
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0};
        apply(v, 1'b1, ga, gb);
        chk("sat_drop_final", s_Drop_Cnt, 2'd3);

        // Randomized traffic obeying the hold-until-ready protocol.
        pa = 0; pb = 0;
        ra_a = '0; rb_a = '0; ra_d = '0; rb_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && ($urandom % 3 != 0)) begin
                pa = 1;
                ra_a = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom % 32);
                ra_d = $urandom;
            end
            if (!pb && ($urandom % 3 != 0)) begin
                pb = 1;
                rb_a = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom % 32);
                rb_d = $urandom;
            end
            v.clr  = ($urandom % 40 == 0);
            v.hold = ($urandom % 5 == 0);
            v.av = pa; v.aa = ra_a; v.ad = ra_d;
            v.bv = pb; v.ba = rb_a; v.bd = rb_d;
            v.ear = 0; v.ebr = 0; v.ewr = 0; v.ewa = 0; v.ewd = 0;
            v.edrop = 0; v.econf = 0;
            apply(v, 1'b0, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU result path) and B (memory-load path).
- Arbitrates round-robin using valid/ready handshakes. Registers the winning write, which drives Write_Reg/W_Addr/W_Data one cycle later.
- Discards writes to register 0 and exposes the in-flight write for hazard/forwarding logic.
- Sits between the execute/memory stages and the register file.

Parameters:
ADDR, 5, register address width
SIZE, 32, register data width
CNT_W, 8, width of saturating statistics counters

Ports:
Clk  input  1  clock; all state updates on rising edge
Clr  input  1  synchronous active-high reset
Hold  input  1  freeze arbitration; no grants while high
A_Valid  input  1  requester A has a write pending
A_Addr  input  ADDR  requester A destination register
A_Data  input  SIZE  requester A write data
A_Ready  output  1  A granted this cycle (combinational)
B_Valid  input  1  requester B has a write pending
B_Addr  input  ADDR  requester B destination register
B_Data  input  SIZE  requester B write data
B_Ready  output  1  B granted this cycle (combinational)
Write_Reg  output  1  register-file write enable (registered)
W_Addr  output  ADDR  register-file write address (registered)
W_Data  output  SIZE  register-file write data (registered)
Drop_Cnt  output  CNT_W  accepted writes to register 0, saturating
Conflict_Cnt  output  CNT_W  cycles with both requesters valid and Hold low, saturating

Behaviour:
- Reset (Clr=1 at a rising edge):
  - Write_Reg=0, W_Addr=0, W_Data=0.
  - rr pointer = A (A preferred first).
  - Drop_Cnt=0, Conflict_Cnt=0.
  - A_Ready and B_Ready are forced 0 while Clr is high.
- Handshake:
  - A transfer occurs on a cycle where Valid&Ready.
  - A requester must hold Valid, Addr and Data stable until Ready.
  - Ready depends only on both Valid inputs, Hold, Clr and the rr pointer. It never depends on Addr or Data.
- Grant rules (Hold=0, Clr=0):
  - Only A valid -> A_Ready=1.
  - Only B valid -> B_Ready=1.
  - Both valid -> the source named by the rr pointer wins; the other source's Ready=0.
  - Neither valid -> no grant.
  - A_Ready and B_Ready are never both 1.
- rr pointer:
  - Updates only on a transfer, to the source that did not transfer.
  - Single-source traffic therefore leaves priority with the idle source for the next conflict.
- Hold=1: both Ready=0, pointer unchanged, Conflict_Cnt not incremented. Write_Reg is 0 on the next cycle.
- Output stage (1-cycle latency):
  - On a transfer with Addr!=0: next cycle Write_Reg=1, W_Addr/W_Data = the granted Addr/Data.
  - On a transfer with Addr==0: next cycle Write_Reg=0, W_Addr/W_Data keep their previous values, Drop_Cnt+1.
  - No transfer: Write_Reg=0, W_Addr/W_Data hold their previous values.
- Back-to-back throughput: one write per cycle. Consecutive writes to the same address are both issued, in grant order.
- Counters: saturate at 2^CNT_W-1; no wrap-around.
- Clr mid-operation:
  - Any registered but not yet visible write is discarded; Write_Reg=0 the cycle after Clr.
  - Requests presented during Clr are not accepted and must remain valid afterwards.
- Hazard visibility: Write_Reg/W_Addr are the in-flight write. Read-after-write logic compares R_Addr against W_Addr while Write_Reg=1.

Test Plan:
- Reset then single A write: A_Valid=1, A_Addr=5, A_Data=0x1234 -> A_Ready=1 same cycle; next cycle Write_Reg=1, W_Addr=5, W_Data=0x1234; afterwards Write_Reg=0.
- Both requesters valid for 4 cycles (A: addr 1..4, B: addr 9..12, each advancing on its own Ready):
  - Grants alternate A,B,A,B.
  - W_Addr sequence 1,9,2,10.
  - Conflict_Cnt=4.
- Register-0 filter: B writes addr 0, data 0xFFFF -> B_Ready=1; next cycle Write_Reg=0, W_Addr/W_Data unchanged, Drop_Cnt=1.
- Hold during contention: both valid, Hold=1 for 3 cycles -> both Ready=0, Write_Reg=0, Conflict_Cnt unchanged. On Hold release, the pointer-selected source is granted first.
- Clr mid-stream: A transfers addr 7 in cycle N; Clr=1 in cycle N+1 -> Write_Reg=0 in cycle N+2, counters 0, pointer=A.
- Saturation with CNT_W=2: 5 consecutive writes to addr 0 -> Drop_Cnt reads 3 and stays 3.
